// File: rtl/fifo_read_packer.sv
// Read-side drain of the async FIFO: pops entries with one-cycle read latency and packs LANES of them into one valid/ready word.
// Optional partial-word flush after TIMEOUT idle cycles is compiled in with `define PACKER_TIMEOUT_EN.
module fifo_read_packer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         fifo_empty,
    input  logic [WIDTH-1:0]             fifo_data,
    output logic                         fifo_rd_en,
    output logic [WIDTH*LANES-1:0]       m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(LANES+1)-1:0]   m_count
);

    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] FULL = CW'(LANES);
    // An illegal parameter set leaves the packer inert rather than corrupting words.
    localparam bit CFG_OK = (LANES >= 2) && (TIMEOUT >= 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        pending_q;
    logic [LANES-1:0][WIDTH-1:0] data_q, data_d;
    logic                        pop_c;
    logic                        m_valid_d;
    logic [CW-1:0]               m_count_d;

`ifdef PACKER_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0]               idle_q, idle_d;
`endif

    // Next-state, pop decision and lane capture.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        pop_c     = 1'b0;
`ifdef PACKER_TIMEOUT_EN
        idle_d    = idle_q;
`endif
        case (state_q)
            FILL: begin
                pop_c = CFG_OK && !fifo_empty && !rd_rst &&
                        ((count_q + CW'(pending_q)) < FULL);
                if (pending_q) begin
                    data_d[LW'(count_q)] = fifo_data;
                    count_d              = count_q + CW'(1);
                end
                if (count_d == FULL) begin
                    state_d = HOLD;
                end
`ifdef PACKER_TIMEOUT_EN
                // Idle means a partial word with nothing in flight and nothing being popped.
                if (pending_q) begin
                    idle_d = '0;
                end else if ((count_q != '0) && !pop_c) begin
                    idle_d = idle_q + IW'(1);
                    if (idle_d == IW'(TIMEOUT)) begin
                        state_d = HOLD;
                    end
                end
`endif
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    data_d  = '0;
`ifdef PACKER_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            default: state_d = FILL;
        endcase

        m_valid_d = (state_d == HOLD);
`ifdef PACKER_TIMEOUT_EN
        m_count_d = m_valid_d ? count_d : '0;
`else
        m_count_d = m_valid_d ? FULL : '0;
`endif
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q   <= FILL;
            count_q   <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            m_valid   <= 1'b0;
            m_count   <= '0;
`ifdef PACKER_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pop_c;
            data_q    <= data_d;
            m_valid   <= m_valid_d;
            m_count   <= m_count_d;
`ifdef PACKER_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    assign fifo_rd_en = pop_c;
    assign m_data     = data_q;

endmodule
